apb_gpio_irq: RTL and testbench
===============================

# apb_gpio_irq

Memory-mapped general-purpose I/O peripheral with per-pin interrupt detection. It hangs off one master port of the top-level APB demux, beside the UART, mtimer, I2C and timer peripherals. Its single `irq_o` drives a spare slot of the core's `all_irqs` vector, and the top-level address map gains a `gpio` window for it. Inputs are synchronised, edge/level-qualified and latched into W1C pending bits; outputs and output-enables are register-driven.

## Interface
- `NrGpio`, default 8: number of pins, legal range 1..32; unused register bits read 0 and ignore writes.
- `AddrWidth`, default 32: APB address width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `psel_i`  in  1  APB select.
- `penable_i`  in  1  APB enable.
- `pwrite_i`  in  1  APB write.
- `paddr_i`  in  AddrWidth  APB address; only `[4:0]` is decoded.
- `pwdata_i`  in  32  APB write data.
- `prdata_o`  out  32  APB read data.
- `pready_o`  out  1  APB ready.
- `pslverr_o`  out  1  APB error.
- `gpio_i`  in  NrGpio  asynchronous pad inputs.
- `gpio_o`  out  NrGpio  pad output values (OUT register).
- `gpio_oe_o`  out  NrGpio  pad output enables (DIR register).
- `irq_o`  out  1  registered interrupt, level-high.

## Operation
- Register map, by byte offset:
  - 0x00 DIR (RW): output enables.
  - 0x04 OUT (RW): output values.
  - 0x08 IN (RO): synchronised inputs.
  - 0x0C IRQ_EN (RW): per-pin interrupt mask.
  - 0x10 IRQ_TYPE (RW): 0 = level, 1 = edge.
  - 0x14 IRQ_POL (RW): 0 = high/rising, 1 = low/falling.
  - 0x18 IRQ_PEND (RW1C).
  - 0x1C OUT_TGL (WO): OUT ^= wdata; reads 0.
- Errors: `pslverr_o`=1 on a write to IN, or on `paddr_i[1:0]`≠0. An errored access has no side effects and reads 0.
- Input path: 2-flop synchroniser to `in_q`, plus one history flop `in_d`.
  - rise = `in_q & ~in_d`; fall = `~in_q & in_d`.
- Event per pin:
  - TYPE=1: POL ? fall : rise.
  - TYPE=0: POL ? ~in_q : in_q.
- Pending register: PEND |= event every cycle, regardless of IRQ_EN.
  - A W1C write clears the written bits.
  - Set and clear in the same cycle: set wins.
  - Level mode re-sets PEND every cycle while the level persists.
- Interrupt: `irq_o` register ← |(PEND & IRQ_EN).
- Config changes: changing TYPE/POL does not by itself fabricate edges, because edge detection uses `in_q`/`in_d` only. A level event may assert immediately on config change.
- Reset values: every register, synchroniser flop and history flop is 0. Therefore `gpio_o`=0, `gpio_oe_o`=0, `irq_o`=0, `prdata_o`=0, `pslverr_o`=0.

## Timing
- APB is zero-wait-state. `pready_o` = `psel_i & penable_i`, combinational.
  - `prdata_o` and `pslverr_o` are combinational during the access phase and 0 otherwise.
  - Register writes commit on the rising edge that ends the access phase. A setup phase alone has no effect.
- `gpio_o`/`gpio_oe_o` update on that same edge.
- Input latency, for a `gpio_i` change stable before edge k:
  - `in_q` valid after edge k+1, so IN reads the new value from cycle k+1.
  - PEND set after edge k+2.
  - `irq_o` high after edge k+3.
- Deassertion: a W1C clear committed at edge j drops `irq_o` after edge j+1, unless the event recurs.
- Mid-operation reset: asynchronous return to the reset values listed under Operation. The in-flight APB transfer is discarded, and the first post-reset edge detection sees `in_d`=0.

## Structure
- `zeroheti_pkg` gains:
  - an `AddrMap.gpio` entry;
  - offset constants `GpioDirOffs` … `GpioTglOffs`;
  - `GpioMaxPins` = 32.
- The top-level demux grows to `NrApbPerip`=5. `irq_o` maps to `all_irqs[12]`.
- Sub-module `gpio_in_sync`: parameterised-width 2-flop synchroniser plus history flop. It outputs `in_q`, `rise` and `fall`.
- Everything else (register file, decode, event/pending logic) lives in `apb_gpio_irq`.

## Test plan
- Reset, then read every offset: all 0; `gpio_o`/`gpio_oe_o`/`irq_o` = 0. Read of 0x1C = 0 with `pslverr_o`=0.
- Output path:
  - Write DIR=0xFF then OUT=0xA5: `gpio_oe_o`=0xFF and `gpio_o`=0xA5 on the edge ending access.
  - Write OUT_TGL=0x0F: `gpio_o`=0xAA.
- Rising edge: IRQ_EN=0x01, TYPE=0x01, POL=0.
  - Drive `gpio_i[0]` 0→1 before edge k: IN[0]=1 from k+1, PEND=0x01 after k+2, `irq_o`=1 after k+3.
  - W1C 0x01 at edge j: `irq_o`=0 after j+1.
- Level-low: TYPE=0, POL=0x02, EN=0x02, `gpio_i[1]`=0 held.
  - W1C 0x02: PEND[1] stays 1 (set wins) and `irq_o` stays 1.
  - Release pin to 1, wait 3 cycles, then W1C: `irq_o`=0.
- Error cases:
  - Write 0x12345678 to 0x08: `pslverr_o`=1, IN unchanged.
  - Access to address 0x06: `pslverr_o`=1, no register change, reads 0.
- Masked event: EN=0, falling edge on pin 3 with TYPE=0x08, POL=0x08.
  - PEND=0x08 and `irq_o`=0.
  - Later write EN=0x08: `irq_o`=1 one cycle after the write edge.
- Mid-operation reset: assert `rst_ni` low mid-transfer with PEND≠0 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/apb_gpio_irq_pkg.sv
// Shared constants for the APB GPIO peripheral: register offsets and pin limit.
package apb_gpio_irq_pkg;

  localparam int unsigned GpioMaxPins = 32;

  // Byte offsets within the gpio window; only paddr[4:0] is decoded.
  localparam logic [4:0] GpioDirOffs     = 5'h00;
  localparam logic [4:0] GpioOutOffs     = 5'h04;
  localparam logic [4:0] GpioInOffs      = 5'h08;
  localparam logic [4:0] GpioIrqEnOffs   = 5'h0C;
  localparam logic [4:0] GpioIrqTypeOffs = 5'h10;
  localparam logic [4:0] GpioIrqPolOffs  = 5'h14;
  localparam logic [4:0] GpioIrqPendOffs = 5'h18;
  localparam logic [4:0] GpioTglOffs     = 5'h1C;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop input synchroniser plus one history flop, giving the synchronised
// level and single-cycle rise/fall strobes.
module gpio_in_sync #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] in_q_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  logic [Width-1:0] meta_q, in_q, hist_q;

  // Synchroniser chain; hist_q holds the previous synchronised sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      in_q   <= '0;
      hist_q <= '0;
    end else begin
      meta_q <= d_i;
      in_q   <= meta_q;
      hist_q <= in_q;
    end
  end

  assign in_q_o = in_q;
  assign rise_o = in_q & ~hist_q;
  assign fall_o = ~in_q & hist_q;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB GPIO peripheral: direction/output registers, synchronised inputs,
// per-pin level/edge interrupt detection into W1C pending bits, one irq line.
module apb_gpio_irq
  import apb_gpio_irq_pkg::*;
#(
  parameter int unsigned NrGpio    = 8,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [31:0]          pwdata_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  input  logic [NrGpio-1:0]    gpio_i,
  output logic [NrGpio-1:0]    gpio_o,
  output logic [NrGpio-1:0]    gpio_oe_o,
  output logic                 irq_o
);

  logic [NrGpio-1:0] dir_q, dir_d, out_q, out_d, en_q, en_d;
  logic [NrGpio-1:0] typ_q, typ_d, pol_q, pol_d, pend_q, pend_d;
  logic              irq_q, irq_d;
  logic [NrGpio-1:0] in_q, rise, fall, evt, clr, rdata, wdata;
  logic [4:0]        addr;
  logic              access, err, we;
  logic              unused_bits;

  gpio_in_sync #(.Width(NrGpio)) u_in_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (gpio_i),
    .in_q_o (in_q),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Upper address bits and write-data bits above NrGpio are ignored.
  assign unused_bits = ^{paddr_i, pwdata_i};

  assign addr  = paddr_i[4:0];
  assign wdata = pwdata_i[NrGpio-1:0];
  // While reset is low the in-flight transfer is dropped, so data/err read 0.
  assign access = psel_i & penable_i & rst_ni;
  assign err    = access & ((addr[1:0] != 2'b00) | (pwrite_i & (addr == GpioInOffs)));
  assign we     = access & pwrite_i & ~err;

  // Per-pin event: edge mode picks rise/fall, level mode picks active level.
  always_comb begin
    evt = (typ_q & ((pol_q & fall) | (~pol_q & rise))) | (~typ_q & (in_q ^ pol_q));
  end

  // Register-file next state; pending set beats a same-cycle W1C clear.
  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    en_d  = en_q;
    typ_d = typ_q;
    pol_d = pol_q;
    clr   = '0;
    if (we) begin
      case (addr)
        GpioDirOffs:     dir_d = wdata;
        GpioOutOffs:     out_d = wdata;
        GpioIrqEnOffs:   en_d  = wdata;
        GpioIrqTypeOffs: typ_d = wdata;
        GpioIrqPolOffs:  pol_d = wdata;
        GpioIrqPendOffs: clr   = wdata;
        GpioTglOffs:     out_d = out_q ^ wdata;
        default:         ;
      endcase
    end
    pend_d = (pend_q & ~clr) | evt;
    irq_d  = |(pend_q & en_q);
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dir_q  <= '0;
      out_q  <= '0;
      en_q   <= '0;
      typ_q  <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      out_q  <= out_d;
      en_q   <= en_d;
      typ_q  <= typ_d;
      pol_q  <= pol_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  // Read mux; OUT_TGL and undecoded offsets read 0.
  always_comb begin
    rdata = '0;
    case (addr)
      GpioDirOffs:     rdata = dir_q;
      GpioOutOffs:     rdata = out_q;
      GpioInOffs:      rdata = in_q;
      GpioIrqEnOffs:   rdata = en_q;
      GpioIrqTypeOffs: rdata = typ_q;
      GpioIrqPolOffs:  rdata = pol_q;
      GpioIrqPendOffs: rdata = pend_q;
      default:         rdata = '0;
    endcase
  end

  assign prdata_o  = (access && !err) ? 32'(rdata) : 32'd0;
  assign pslverr_o = err;
  assign pready_o  = psel_i & penable_i;
  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Bench for apb_gpio_irq: directed APB/pin stimulus, a sample-history model of
// the pin path and register file, and a per-cycle compare against it.
module tb_apb_gpio_irq;
  localparam int N = 8;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, prdata;
  logic        pready, pslverr, irq;
  logic [N-1:0] gpio_i = '0, gpio_o, gpio_oe;
  int n_checks = 0, n_errs = 0;

  always #5 clk = ~clk;

  apb_gpio_irq #(.NrGpio(N), .AddrWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_oe_o(gpio_oe), .irq_o(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // p1/p2/p3: pad value sampled 1, 2, 3 edges ago; the synchronised input is
  // the sample from two edges back, its history the one from three back.
  logic [N-1:0] m_dir = '0, m_out = '0, m_en = '0, m_typ = '0, m_pol = '0, m_pend = '0;
  logic [N-1:0] p1 = '0, p2 = '0, p3 = '0, m_ev, m_clr;
  logic         m_irq = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dir = '0; m_out = '0; m_en = '0; m_typ = '0; m_pol = '0; m_pend = '0;
      p1 = '0; p2 = '0; p3 = '0; m_irq = 1'b0;
    end else begin
      m_ev = '0;
      m_clr = '0;
      for (int i = 0; i < N; i++) begin
        if (m_typ[i]) m_ev[i] = m_pol[i] ? (p3[i] && !p2[i]) : (p2[i] && !p3[i]);
        else          m_ev[i] = (p2[i] != m_pol[i]);
      end
      m_irq = (m_pend & m_en) != 0;
      if (psel && penable && pwrite && paddr[1:0] == 2'b00) begin
        case (paddr[4:0])
          5'h00: m_dir = pwdata[N-1:0];
          5'h04: m_out = pwdata[N-1:0];
          5'h0C: m_en  = pwdata[N-1:0];
          5'h10: m_typ = pwdata[N-1:0];
          5'h14: m_pol = pwdata[N-1:0];
          5'h18: m_clr = pwdata[N-1:0];
          5'h1C: m_out = m_out ^ pwdata[N-1:0];
          default: ;
        endcase
      end
      m_pend = (m_pend & ~m_clr) | m_ev;
      p3 = p2; p2 = p1; p1 = gpio_i;
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [N-1:0] v;
    v = '0;
    case (a)
      5'h00: v = m_dir;
      5'h04: v = m_out;
      5'h08: v = p2;
      5'h0C: v = m_en;
      5'h10: v = m_typ;
      5'h14: v = m_pol;
      5'h18: v = m_pend;
      default: v = '0;
    endcase
    return {{(32-N){1'b0}}, v};
  endfunction

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gpio_o", gpio_o, m_out);
      chk("gpio_oe_o", gpio_oe, m_dir);
      chk("irq_o", irq, m_irq);
      chk("pready_o", pready, psel && penable);
      if (psel && penable && !pwrite) begin
        chk("prdata_o", prdata, m_read(paddr[4:0]));
        chk("pslverr_rd", pslverr, paddr[1:0] != 2'b00);
      end
      if (psel && penable && pwrite)
        chk("pslverr_wr", pslverr, (paddr[1:0] != 2'b00) || (paddr[4:0] == 5'h08));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic e);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    tick();
    penable = 1'b1;
    @(negedge clk);
    e = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic e);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    tick();
    penable = 1'b1;
    @(negedge clk);
    d = prdata;
    e = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gpio_o", gpio_o, 0);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_irq", irq, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", pslverr, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // every offset reads 0 after reset, including OUT_TGL, without error
    for (int a = 0; a < 32; a += 4) begin
      apb_rd(a, d, e);
      chk("rst_rd", d, 0);
      chk("rst_rd_err", e, 0);
    end

    // output path
    apb_wr(32'h00, 32'hFF, e);
    chk("dir_oe", gpio_oe, 32'hFF);
    apb_wr(32'h04, 32'hA5, e);
    chk("out_a5", gpio_o, 32'hA5);
    apb_wr(32'h1C, 32'h0F, e);
    chk("out_tgl", gpio_o, 32'hAA);
    apb_rd(32'h1C, d, e);
    chk("tgl_rd", d, 0);
    chk("tgl_rd_err", e, 0);
    // setup phase alone must not write
    psel = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h00;
    tick();
    psel = 1'b0; pwrite = 1'b0;
    tick();
    chk("setup_only", gpio_o, 32'hAA);

    // rising edge on pin 0
    apb_wr(32'h0C, 32'h01, e);
    apb_wr(32'h10, 32'h01, e);
    apb_wr(32'h14, 32'h00, e);
    gpio_i[0] = 1'b1;           // stable before edge k
    tick(); tick(); tick();     // after k+2
    chk("rise_irq_k2", irq, 0);
    tick();                     // after k+3
    chk("rise_irq_k3", irq, 1);
    apb_rd(32'h08, d, e);
    chk("rise_in", d, 32'h01);
    apb_rd(32'h18, d, e);
    chk("rise_pend", d, 32'h01);
    apb_wr(32'h18, 32'h01, e);  // W1C at edge j
    chk("w1c_irq_j", irq, 1);
    tick();
    chk("w1c_irq_j1", irq, 0);

    // level-low on pin 1
    gpio_i[0] = 1'b0;
    repeat (4) tick();
    apb_wr(32'h14, 32'h02, e);
    apb_wr(32'h10, 32'h00, e);
    apb_wr(32'h0C, 32'h02, e);
    chk("lvl_irq_en_edge", irq, 0);
    tick();
    chk("lvl_irq", irq, 1);
    apb_wr(32'h18, 32'h02, e);
    apb_rd(32'h18, d, e);
    chk("lvl_set_wins", d, 32'h02);
    chk("lvl_irq_held", irq, 1);
    gpio_i[1] = 1'b1;
    tick(); tick(); tick();
    apb_wr(32'h18, 32'h02, e);
    tick();
    chk("lvl_release_irq", irq, 0);
    apb_rd(32'h18, d, e);
    chk("lvl_release_pend", d, 0);

    // error cases
    apb_wr(32'h08, 32'h12345678, e);
    chk("wr_in_err", e, 1);
    apb_rd(32'h08, d, e);
    chk("in_unchanged", d, 32'h02);
    chk("rd_in_err", e, 0);
    apb_wr(32'h06, 32'h00, e);
    chk("misalign_wr_err", e, 1);
    apb_rd(32'h06, d, e);
    chk("misalign_rd_data", d, 0);
    chk("misalign_rd_err", e, 1);
    apb_rd(32'h04, d, e);
    chk("out_kept", d, 32'hAA);
    apb_rd(32'h00, d, e);
    chk("dir_kept", d, 32'hFF);

    // masked falling edge on pin 3
    apb_wr(32'h0C, 32'h00, e);
    apb_wr(32'h10, 32'h08, e);
    apb_wr(32'h14, 32'h0A, e);
    apb_wr(32'h18, 32'hFF, e);
    gpio_i[3] = 1'b1;
    repeat (4) tick();
    gpio_i[3] = 1'b0;
    repeat (4) tick();
    apb_rd(32'h18, d, e);
    chk("mask_pend", d, 32'h08);
    chk("mask_irq", irq, 0);
    apb_wr(32'h0C, 32'h08, e);
    chk("unmask_irq_edge", irq, 0);
    tick();
    chk("unmask_irq", irq, 1);

    // asynchronous reset in the middle of a read of PEND
    psel = 1'b1; pwrite = 1'b0; paddr = 32'h18; penable = 1'b0;
    tick();
    penable = 1'b1;
    #1 chk("pre_rst_prdata", prdata, 32'h08);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_gpio_o", gpio_o, 0);
    chk("arst_gpio_oe", gpio_oe, 0);
    chk("arst_irq", irq, 0);
    chk("arst_prdata", prdata, 0);
    chk("arst_pslverr", pslverr, 0);
    psel = 1'b0; penable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    // defaults are level-high; pin 1 is held high so it pends, masked
    apb_rd(32'h18, d, e);
    chk("post_rst_pend", d, 32'h02);
    apb_rd(32'h00, d, e);
    chk("post_rst_dir", d, 0);
    chk("post_rst_irq", irq, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
